// File: rtl/gshare_branch_predictor.sv
// gshare predictor: PC xor global history indexes a table of 2-bit counters.
// Execute-side resolution trains the table and repairs speculative history on a mispredict.
module gshare_branch_predictor #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BPRED_WIDTH   = 9,
    parameter int HISTORY_WIDTH = 9,
    parameter int STAT_WIDTH    = 32
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_Stall,
    input  logic                     i_Lookup_Valid,
    input  logic                     i_Lookup_Is_Branch,
    input  logic [ADDRESS_WIDTH-1:0] i_Lookup_PC,
    output logic                     o_Prediction,
    output logic [BPRED_WIDTH-1:0]   o_Index,
    input  logic                     i_Resolve_Valid,
    input  logic [BPRED_WIDTH-1:0]   i_Resolve_Index,
    input  logic                     i_Resolve_Prediction,
    input  logic                     i_Resolve_Taken,
    output logic                     o_Mispredict,
    output logic [STAT_WIDTH-1:0]    o_Branch_Count,
    output logic [STAT_WIDTH-1:0]    o_Mispredict_Count
);

    localparam int         PHT_DEPTH   = 1 << BPRED_WIDTH;
    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] CTR_MAX     = 2'b11;
    localparam logic [1:0] CTR_MIN     = 2'b00;

    logic [1:0]               pht_q [PHT_DEPTH];
    logic [1:0]               pht_d;
    logic [1:0]               resolve_ctr;
    logic [HISTORY_WIDTH-1:0] spec_ghr_q;
    logic [HISTORY_WIDTH-1:0] spec_ghr_d;
    logic [HISTORY_WIDTH-1:0] commit_ghr_q;
    logic [HISTORY_WIDTH-1:0] commit_ghr_d;
    logic [STAT_WIDTH-1:0]    branch_cnt_q;
    logic [STAT_WIDTH-1:0]    branch_cnt_d;
    logic [STAT_WIDTH-1:0]    mispred_cnt_q;
    logic [STAT_WIDTH-1:0]    mispred_cnt_d;
    logic [BPRED_WIDTH-1:0]   lookup_index;
    logic                     lookup_pred;
    logic                     lookup_shift;
    logic                     mispredict;
    logic                     unused_pc_bits;

    // Only the word-address bits that fit the table index take part in the hash.
    assign unused_pc_bits = ^{i_Lookup_PC[ADDRESS_WIDTH-1:BPRED_WIDTH+2], i_Lookup_PC[1:0]};

    assign lookup_index = i_Lookup_PC[BPRED_WIDTH+1:2] ^ BPRED_WIDTH'(spec_ghr_q);
    assign lookup_pred  = pht_q[lookup_index][1];
    assign lookup_shift = i_Lookup_Valid & i_Lookup_Is_Branch & ~i_Stall;
    assign mispredict   = i_Resolve_Valid & (i_Resolve_Prediction != i_Resolve_Taken);

    assign o_Index            = lookup_index;
    assign o_Prediction       = lookup_pred;
    assign o_Mispredict       = mispredict;
    assign o_Branch_Count     = branch_cnt_q;
    assign o_Mispredict_Count = mispred_cnt_q;

    always_comb begin
        resolve_ctr = pht_q[i_Resolve_Index];
        pht_d       = resolve_ctr;
        if (i_Resolve_Taken) begin
            if (resolve_ctr != CTR_MAX) begin
                pht_d = resolve_ctr + 2'd1;
            end
        end else if (resolve_ctr != CTR_MIN) begin
            pht_d = resolve_ctr - 2'd1;
        end
    end

    // A mispredict flushes fetch, so the repaired history overrides any same-cycle lookup shift.
    always_comb begin
        commit_ghr_d = commit_ghr_q;
        if (i_Resolve_Valid) begin
            commit_ghr_d = (commit_ghr_q << 1) | HISTORY_WIDTH'(i_Resolve_Taken);
        end
        spec_ghr_d = spec_ghr_q;
        if (mispredict) begin
            spec_ghr_d = commit_ghr_d;
        end else if (lookup_shift) begin
            spec_ghr_d = (spec_ghr_q << 1) | HISTORY_WIDTH'(lookup_pred);
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (i_Resolve_Valid && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + STAT_WIDTH'(1);
        end
        if (mispredict && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i] <= CTR_WEAK_NT;
            end
        end else if (i_Resolve_Valid) begin
            pht_q[i_Resolve_Index] <= pht_d;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            spec_ghr_q    <= '0;
            commit_ghr_q  <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            spec_ghr_q    <= spec_ghr_d;
            commit_ghr_q  <= commit_ghr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule
